// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - load/store sequencer between execute stage and word-ported data cache
// Sub-word stores run as read-modify-write; loads are lane-extracted and extended.
module dmem_access_unit #(
    parameter int WIDTH     = 32,
    parameter int WIDTH_ADD = 5,
    parameter int BYTE      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [WIDTH_ADD-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 resp_valid,
    output logic [WIDTH-1:0]     resp_rdata,
    output logic                 resp_err,
    output logic [WIDTH_ADD-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_we,
    input  logic [WIDTH-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t state, state_next;

    logic                 l_we;
    logic [1:0]           l_size;
    logic                 l_signed;
    logic [WIDTH_ADD-1:0] l_addr;
    logic [WIDTH-1:0]     l_wdata;
    logic [WIDTH-1:0]     l_word;
    logic                 l_err;

    logic       accept;
    logic       req_err;
    logic [4:0] byte_sh;
    logic [4:0] half_sh;
    logic [BYTE-1:0]   byte_v;
    logic [2*BYTE-1:0] half_v;
    logic [WIDTH-1:0]  load_data;
    logic [WIDTH-1:0]  merged;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_err   = (req_size == 2'b11) ||
                       (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            l_we     <= 1'b0;
            l_size   <= 2'b00;
            l_signed <= 1'b0;
            l_addr   <= '0;
            l_wdata  <= '0;
            l_word   <= '0;
            l_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                l_we     <= req_we;
                l_size   <= req_size;
                l_signed <= req_signed;
                l_addr   <= req_addr;
                l_wdata  <= req_wdata;
                l_err    <= req_err;
            end
            if (state == READ) begin
                l_word <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_we && req_size == 2'b10)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = l_we ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign byte_sh = {l_addr[1:0], 3'b000};
    assign half_sh = {l_addr[1], 4'b0000};
    assign byte_v  = l_word[byte_sh +: BYTE];
    assign half_v  = l_word[half_sh +: 2*BYTE];

    always_comb begin
        load_data = l_word;
        case (l_size)
            2'b00:   load_data = {{(WIDTH-BYTE){l_signed & byte_v[BYTE-1]}}, byte_v};
            2'b01:   load_data = {{(WIDTH-2*BYTE){l_signed & half_v[2*BYTE-1]}}, half_v};
            default: load_data = l_word;
        endcase
    end

    // Word stores never read, so the merge only splices into the captured old word for sub-word sizes.
    always_comb begin
        merged = l_word;
        case (l_size)
            2'b00:   merged[byte_sh +: BYTE]   = l_wdata[BYTE-1:0];
            2'b01:   merged[half_sh +: 2*BYTE] = l_wdata[2*BYTE-1:0];
            default: merged = l_wdata;
        endcase
    end

    assign mem_we     = (state == WRITE);
    assign mem_addr   = {l_addr[WIDTH_ADD-1:2], 2'b00};
    assign mem_wdata  = merged;
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && l_err;
    assign resp_rdata = (state == RESP && !l_we && !l_err) ? load_data : '0;

endmodule
